// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional macro MULDIV_CANCEL_EN adds a cancel input that flushes an operation in RUN.
module hilo_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef MULDIV_CANCEL_EN
   input  logic             cancel,
`endif
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] RS,
   input  logic [WIDTH-1:0] RT,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] p_hi_q, p_lo_q, b_q, rs_q;
   logic             is_div_q, neg_q, neg_rem_q, div_zero_q;
   logic             cancel_run, finish;

`ifdef MULDIV_CANCEL_EN
   assign cancel_run = cancel;
`else
   assign cancel_run = 1'b0;
`endif

   assign finish = (state_q == RUN) && !cancel_run && (count_q == CW'(1));

   // Operand magnitudes; op[0]=0 selects the signed variants.
   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      signed_op = ~op[0];
      a_neg     = signed_op & RS[WIDTH-1];
      b_neg     = signed_op & RT[WIDTH-1];
      a_mag     = a_neg ? -RS : RS;
      b_mag     = b_neg ? -RT : RT;
   end

   // One iteration: shift-add for multiply, restoring step for divide.
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH-1:0]   div_diff, p_hi_d, p_lo_d;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   hi_res, lo_res;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      hi_res    = '0;
      lo_res    = '0;
      mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      div_diff  = div_shift[WIDTH-1:0] - b_q;
      if (is_div_q) begin
         p_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
         p_lo_d = {p_lo_q[WIDTH-2:0], div_ge};
      end else begin
         p_hi_d = mul_sum[WIDTH:1];
         p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
      end
      prod   = {p_hi_d, p_lo_d};
      prod_s = neg_q ? -prod : prod;
      if (!is_div_q) begin
         hi_res = prod_s[2*WIDTH-1:WIDTH];
         lo_res = prod_s[WIDTH-1:0];
      end else if (div_zero_q) begin
         hi_res = rs_q;
         lo_res = '1;
      end else begin
         hi_res = neg_rem_q ? -p_hi_d : p_hi_d;
         lo_res = neg_q ? -p_lo_d : p_lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (cancel_run) state_d = IDLE;
            else if (finish) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         p_hi_q     <= '0;
         p_lo_q     <= '0;
         b_q        <= '0;
         rs_q       <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         count_q    <= CW'(WIDTH);
         p_hi_q     <= '0;
         p_lo_q     <= a_mag;
         b_q        <= b_mag;
         rs_q       <= RS;
         is_div_q   <= op[1];
         neg_q      <= a_neg ^ b_neg;
         neg_rem_q  <= a_neg;
         div_zero_q <= op[1] && (RT == '0);
      end else if (state_q == RUN) begin
         count_q <= count_q - CW'(1);
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
      end
   end

   // MT writes land whenever not busy; a result written later simply overwrites them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HI <= '0;
         LO <= '0;
      end else if (finish) begin
         HI <= hi_res;
         LO <= lo_res;
      end else if (state_q != RUN) begin
         if (mthi) HI <= wdata;
         if (mtlo) LO <= wdata;
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: expected HI/LO pushed to a scoreboard at
// start and popped on done; latency, done pulse, MT writes, reset and cancel checked.
module tb_hilo_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] rs = '0, rt = '0, wdata = '0;
   logic         mthi = 1'b0, mtlo = 1'b0, cancel = 1'b0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef MULDIV_CANCEL_EN
      .cancel(cancel),
`endif
      .start (start),
      .op    (op),
      .RS    (rs),
      .RT    (rt),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .HI    (hi),
      .LO    (lo)
   );

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation; optionally poke start/mthi/mtlo mid-run and confirm they are ignored.
   task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit inject);
      int n;
      logic [W-1:0] hi_before, lo_before;
      exp_t e;
      sb.push_back('{hi: eh, lo: el, name: name});
      op = o; rs = a; rt = b; start = 1'b1;
      step();
      start = 1'b0; rs = $urandom; rt = $urandom;
      hi_before = hi; lo_before = lo;
      n = 0;
      while (busy && n < 100) begin
         n++;
         if (inject && n == 3) begin
            mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1111_1111; start = 1'b1; op = 2'b10;
         end
         if (inject && n == 4) begin
            mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
            check({name, " lo_held_in_run"}, lo, lo_before);
            check({name, " hi_held_in_run"}, hi, hi_before);
         end
         step();
      end
      check({name, " busy_cycles"}, n, W);
      check({name, " done"}, {31'b0, done}, 32'd1);
      e = sb.pop_front();
      check({e.name, " HI"}, hi, e.hi);
      check({e.name, " LO"}, lo, e.lo);
      start = 1'b1; op = 2'b01; rs = 32'd9; rt = 32'd9;
      step();
      start = 1'b0;
      check({name, " done_one_cycle"}, {31'b0, done}, 32'd0);
      check({name, " start_in_done_ignored"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #2;
      check("reset HI", hi, 32'd0);
      check("reset LO", lo, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
      do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      do_op("divu",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        0);
      do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0);
      do_op("div_zero",  2'b10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0);
      do_op("mult_minsq",2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
      do_op("mult_negneg",2'b00,32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,         32'd6,         0);
      do_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 0);

      mthi = 1'b1; wdata = 32'hDEAD_BEEF;
      step();
      mthi = 1'b0;
      check("mthi HI", hi, 32'hDEAD_BEEF);
      mtlo = 1'b1; wdata = 32'h0BAD_F00D;
      step();
      mtlo = 1'b0;
      check("mtlo LO", lo, 32'h0BAD_F00D);
      check("mtlo HI kept", hi, 32'hDEAD_BEEF);

      do_op("multu_inject", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1);

      // Asynchronous reset in the middle of an operation.
      op = 2'b01; rs = 32'h0000_1234; rt = 32'h0000_5678; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i < 10; i++) step();
      check("busy before reset", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async reset HI", hi, 32'd0);
      check("async reset LO", lo, 32'd0);
      check("async reset busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      do_op("multu_after_reset", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 0);

`ifdef MULDIV_CANCEL_EN
      begin
         int seen_done;
         op = 2'b00; rs = 32'd1000; rt = 32'd1000; start = 1'b1;
         step();
         start = 1'b0;
         for (int i = 1; i < 5; i++) step();
         cancel = 1'b1;
         step();
         cancel = 1'b0;
         check("cancel busy", {31'b0, busy}, 32'd0);
         seen_done = 0;
         for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            step();
         end
         check("cancel no done", seen_done, 32'd0);
         check("cancel HI", hi, 32'd0);
         check("cancel LO", lo, 32'd15);
      end
`endif

      check("scoreboard empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
